// File: rtl/oled_frame_streamer.sv
// -----------------------------------------------------------------------------
// oled_frame_streamer
//
// Double-buffered 128x64 monochrome frame store sitting in front of the SPI
// OLED driver. Pixel logic writes bytes into the back bank; on frame_start
// the front bank is streamed out as COLS*PAGES bytes (page-major,
// column-minor). A bank swap request is deferred to a frame boundary so
// the panel never shows a torn frame.
//
// Build option:
//   OLED_FS_AUTO_REPEAT_EN  when defined, the streamer restarts at byte 0
//                           right after the final handshake instead of
//                           returning to IDLE (one frame_start after reset).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   wr_en        write strobe into the back bank
//   wr_addr      byte address = page*COLS + column
//   wr_data      byte, bit0 = top pixel row of the page
//   swap_req     pulse, exchange banks at the next frame boundary
//   frame_start  pulse, begin streaming the front bank (IDLE only)
//   out_valid    out_data holds a valid byte
//   out_ready    consumer accepts the byte
//   out_data     streamed byte
//   out_last     high with the final byte of the frame
//   busy         streaming in progress
//   front_bank   bank currently being displayed
//   frame_done   one-cycle pulse after the final byte is accepted
//   dbg_state    current FSM state (0=IDLE, 1=READ, 2=PRESENT)
//
// Output handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_last hold stable. out_ready is ignored when out_valid
// is low. Once out_valid rises it stays high until the transfer happens.
// -----------------------------------------------------------------------------
module oled_frame_streamer #(
    parameter int COLS   = 128,
    parameter int PAGES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              swap_req,
    input  logic              frame_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              front_bank,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    localparam int                DEPTH     = COLS * PAGES;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_swap_now;
    logic              w_handshake;
    logic              w_final;

    logic [7:0]        r_mem [0:1][0:DEPTH-1];
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_out_last;
    logic              r_front_bank;
    logic              r_swap_pending;
    logic              r_frame_done;

    assign w_handshake = r_out_valid && out_ready;
    assign w_final     = (r_state == S_PRESENT) && w_handshake && r_out_last;

    // Next state and swap decision. A swap is applied only at a frame
    // boundary: immediately when idle, otherwise on the final handshake.
    always_comb begin
        w_state_next = r_state;
        w_swap_now   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_swap_now = swap_req || r_swap_pending;
                if (frame_start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_handshake) begin
                    if (r_out_last) begin
                        w_swap_now = swap_req || r_swap_pending;
`ifdef OLED_FS_AUTO_REPEAT_EN
                        w_state_next = S_READ;
`else
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rd_addr      <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 8'h00;
            r_out_last     <= 1'b0;
            r_front_bank   <= 1'b0;
            r_swap_pending <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_final;

            // Repeated requests while busy collapse into one pending swap.
            if (w_swap_now) begin
                r_front_bank   <= ~r_front_bank;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_rd_addr <= '0;
                    end
                end
                S_READ: begin
                    r_out_data  <= r_mem[r_front_bank][r_rd_addr];
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rd_addr == LAST_ADDR);
                end
                S_PRESENT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_out_last <= 1'b0;
                            r_rd_addr  <= '0;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Frame store, not cleared by reset. Writes use the pre-edge front_bank,
    // so a write coinciding with a swap lands in the bank that becomes front.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            r_mem[~r_front_bank][wr_addr] <= wr_data;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = (r_state != S_IDLE);
    assign front_bank = r_front_bank;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_oled_frame_streamer.sv
module tb_oled_frame_streamer;

  localparam int DEPTH = 1024;
`ifdef OLED_FS_AUTO_REPEAT_EN
  localparam logic EXP_BUSY_AFTER = 1'b1;
`else
  localparam logic EXP_BUSY_AFTER = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       frame_start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       front_bank;
  logic       frame_done;
  logic [1:0] dbg_state;

  oled_frame_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .front_bank  (front_bank),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state: {last, data}
  logic [8:0] exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc = 0;
  int   n_done = 0;
  logic sb_strict = 1'b1;
  logic exp_front_after = 1'b0;
  logic rdy_mode = 1'b0;
  logic rdy_fixed = 1'b1;
  logic prev_stall = 1'b0;
  logic prev_final = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // monitor: runs at every falling edge
  task automatic mon_step();
    logic [8:0] e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_final = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (prev_final || frame_done)
        chk("frame_done_pulse", frame_done, prev_final);
      if (prev_final) begin
        chk("busy_after_final", busy, EXP_BUSY_AFTER);
        chk("front_after_final", front_bank, exp_front_after);
      end
      if (frame_done) n_done++;
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_byte", {out_last, out_data}, e);
        end else if (sb_strict) begin
          chk("unexpected_byte", {out_last, out_data}, 9'h1ff + 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_final = out_valid && out_ready && out_last;
    end
  endtask

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic use_const, input logic [7:0] v);
    for (int k = 0; k < DEPTH; k++) begin
      wr_en   = 1'b1;
      wr_addr = k[9:0];
      wr_data = use_const ? v : k[7:0];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input logic use_const, input logic [7:0] v);
    for (int k = 0; k < DEPTH; k++)
      exp_q.push_back({(k == DEPTH - 1), (use_const ? v : k[7:0])});
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic wait_bytes(input string nm, input int target, input int budget);
    int c = 0;
    while (n_acc < target && c < budget) begin
      tick();
      c++;
    end
    chk(nm, (n_acc >= target), 1);
  endtask

  task automatic main_seq();
    int base;
    int d0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    swap_req = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_front_bank", front_bank, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", dbg_state, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef OLED_FS_AUTO_REPEAT_EN
    // single frame_start, three frames back to back
    fill(1'b0, 8'h00);
    pulse_swap();
    chk("ar_swap_idle", front_bank, 1);
    exp_front_after = 1'b1;
    repeat (3) push_frame(1'b0, 8'h00);
    d0 = n_done;
    pulse_start();
    wait_drain("ar_drain", 7000);
    sb_strict = 1'b0;
    chk("ar_frame_done_count", n_done - d0, 3);
    chk("ar_busy_held", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ar_rst_busy", busy, 0);
`else
    // T1: ramp pattern in bank1, swap while idle, full-rate stream
    fill(1'b0, 8'h00);
    pulse_swap();
    chk("t1_swap_idle", front_bank, 1);
    exp_front_after = 1'b1;
    push_frame(1'b0, 8'h00);
    d0 = n_done;
    pulse_start();
    wait_drain("t1_drain", 2300);
    chk("t1_frame_done_count", n_done - d0, 1);
    chk("t1_busy_low", busy, 0);

    // T2: same frame with a random consumer
    rdy_mode = 1'b1;
    push_frame(1'b0, 8'h00);
    d0 = n_done;
    pulse_start();
    wait_drain("t2_drain", 9000);
    rdy_mode = 1'b0;
    chk("t2_frame_done_count", n_done - d0, 1);

    // T3: deferred swap with back-bank rewrite mid-frame
    fill(1'b1, 8'hAA);
    pulse_swap();
    chk("t3_swap_idle", front_bank, 0);
    push_frame(1'b1, 8'hAA);
    exp_front_after = 1'b1;
    base = n_acc;
    pulse_start();
    wait_bytes("t3_reach_500", base + 500, 1200);
    pulse_swap();
    chk("t3_swap_deferred", front_bank, 0);
    pulse_swap();
    fill(1'b1, 8'h55);
    wait_drain("t3_drain", 1500);
    chk("t3_front_toggled_once", front_bank, 1);
    push_frame(1'b1, 8'h55);
    pulse_start();
    wait_drain("t3b_drain", 2300);

    // T4: swap and frame_start in the same idle cycle
    exp_front_after = 1'b0;
    push_frame(1'b1, 8'hAA);
    swap_req = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    chk("t4_valid_after_1st_edge", out_valid, 0);
    chk("t4_front_swapped", front_bank, 0);
    @(negedge clk);
    chk("t4_valid_after_2nd_edge", out_valid, 1);
    chk("t4_first_byte_new_bank", out_data, 8'hAA);
    tick();
    wait_drain("t4_drain", 2300);

    // T5: reset in the middle of a frame
    fill(1'b0, 8'h00);
    pulse_swap();
    chk("t5_swap_idle", front_bank, 1);
    push_frame(1'b0, 8'h00);
    base = n_acc;
    pulse_start();
    wait_bytes("t5_reach_300", base + 300, 800);
    d0 = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_front", front_bank, 0);
    repeat (4) tick();
    chk("t5_no_frame_done", n_done - d0, 0);
    pulse_swap();
    exp_front_after = 1'b1;
    push_frame(1'b0, 8'h00);
    pulse_start();
    wait_drain("t5_restart_drain", 2300);
    chk("t5_restart_frame_done", n_done - d0, 1);
`endif
  endtask

  initial begin
    out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
      end
      main_seq();
      begin
        #1000000;
        chk("watchdog_timeout", 1, 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
